cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant of one result producer per cycle onto a registered CDB.
// Define CDB_ARB_MEM_PRIORITY_EN to give source 0 (memory) fixed priority over the round-robin sources.

package cdb_pkg;

    typedef struct packed {
        logic [3:0]  dest_rob_entry;
        logic [31:0] result;
        logic        branch_result;
        logic        load_step1;
    } cdb_packet_t;

endpackage

module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int N_SRC = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SRC-1:0]   src_valid,
    input  cdb_packet_t        src_packet [N_SRC],
    output logic [N_SRC-1:0]   src_yummy,
    input  logic               flush,
    output cdb_packet_t        cdb_out,
    output logic               cdb_valid,
    output logic [15:0]        grant_count
);

    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] next_ptr;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] rr_req;
    logic             grant;
    logic             advance;

    // Winner search: first requesting index at or above rr_ptr, wrapping to 0.
    always_comb begin : arbitrate
        int idx;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        idx      = 0;
        grant    = 1'b0;
        winner   = '0;
        eligible = flush ? '0 : src_valid;
`ifdef CDB_ARB_MEM_PRIORITY_EN
        rr_req   = eligible & ~N_SRC'(1);
`else
        rr_req   = eligible;
`endif
        for (int k = 0; k < N_SRC; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_SRC) begin
                idx = idx - N_SRC;
            end
            if (!grant && rr_req[idx]) begin
                grant  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
        advance = grant;
`ifdef CDB_ARB_MEM_PRIORITY_EN
        // Memory results bypass the rotation and leave the pointer where it was.
        if (eligible[0]) begin
            grant   = 1'b1;
            winner  = '0;
            advance = 1'b0;
        end
`endif
    end

    assign next_ptr = (int'(winner) == N_SRC - 1) ? '0 : winner + PTR_W'(1);

    // Yummy is gated by reset so an asserting reset kills the pulse without waiting for clk.
    always_comb begin
        src_yummy = '0;
        if (grant && reset) begin
            src_yummy[winner] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cdb_valid   <= 1'b0;
            cdb_out     <= '0;
            rr_ptr      <= '0;
            grant_count <= '0;
        end else begin
            cdb_valid <= grant;
            if (grant) begin
                cdb_out <= src_packet[winner];
            end
            if (advance) begin
                rr_ptr <= next_ptr;
            end
            if (grant && grant_count != 16'hFFFF) begin
                grant_count <= grant_count + 16'd1;
            end
        end
    end

endmodule
